// File: rtl/game_level_ctrl.sv
// Pinball level/lives sequencer. It steps through start, play, ball-lost and
// level-up delays, and it drives the wall colour and the restart pulse for the background drawer.
module game_level_ctrl #(
  parameter int HITS_PER_LEVEL = 8,
  parameter int LIVES          = 3,
  parameter int DELAY_FRAMES   = 60
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       start_key,
  input  logic       ball_lost,
  input  logic       target_hit,
  output logic       new_game,
  output logic [7:0] levelRGB,
  output logic [1:0] level,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_LOST  = 3'd3;
  localparam logic [2:0] S_LVLUP = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [3:0] HITS_TGT   = 4'(HITS_PER_LEVEL);
  localparam logic [7:0] DELAY_TGT  = 8'(DELAY_FRAMES);

  logic [2:0] state_q, state_d;
  logic [3:0] hits_q, hits_d;
  logic [7:0] frame_q, frame_d;
  logic [1:0] level_q, level_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] rgb_q, rgb_d;
  logic       prevKey_q;
  logic       armed_q;
  logic       startEdge;

  // armed_q stays low until the key has been seen released after reset,
  // so a key already held at reset release cannot start a game.
  assign startEdge = start_key & ~prevKey_q & armed_q;

  always_comb begin
    state_d = state_q;
    hits_d  = hits_q;
    frame_d = frame_q;
    level_d = level_q;
    lives_d = lives_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (startEdge) begin
          level_d = 2'd0;
          lives_d = LIVES_INIT;
          hits_d  = 4'd0;
          state_d = S_START;
        end
      end
      S_START: state_d = S_PLAY;
      S_PLAY: begin
        // A ball loss in the same cycle as a hit takes priority and drops the hit.
        if (ball_lost) begin
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          frame_d = 8'd0;
          state_d = S_LOST;
        end else if (target_hit) begin
          if (hits_q + 4'd1 == HITS_TGT) begin
            hits_d  = 4'd0;
            level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
            frame_d = 8'd0;
            state_d = S_LVLUP;
          end else begin
            hits_d = hits_q + 4'd1;
          end
        end
      end
      S_LOST, S_LVLUP: begin
        if (frame_q == DELAY_TGT) begin
          state_d = (state_q == S_LOST && lives_q == 2'd0) ? S_OVER : S_START;
        end else if (startOfFrame) begin
          frame_d = frame_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Colour follows the registered level/state, so it lags them by one clock.
  always_comb begin
    rgb_d = 8'h03;
    if (state_q == S_OVER) begin
      rgb_d = 8'h92;
    end else begin
      case (level_q)
        2'd0:    rgb_d = 8'h03;
        2'd1:    rgb_d = 8'h1C;
        2'd2:    rgb_d = 8'hE0;
        default: rgb_d = 8'hFC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      hits_q    <= 4'd0;
      frame_q   <= 8'd0;
      level_q   <= 2'd0;
      lives_q   <= LIVES_INIT;
      rgb_q     <= 8'h03;
      prevKey_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hits_q    <= hits_d;
      frame_q   <= frame_d;
      level_q   <= level_d;
      lives_q   <= lives_d;
      rgb_q     <= rgb_d;
      prevKey_q <= start_key;
      armed_q   <= armed_q | ~start_key;
    end
  end

  assign new_game  = (state_q == S_START);
  assign game_over = (state_q == S_OVER);
  assign level     = level_q;
  assign lives     = lives_q;
  assign levelRGB  = rgb_q;

endmodule

// File: doc/game_level_ctrl.md
GAME_LEVEL_CTRL -- requirements
Module: game_level_ctrl

Interface
REQ-001 Parameter HITS_PER_LEVEL, default 8, target hits needed to advance one level (legal 1..15).
REQ-002 Parameter LIVES, default 3, balls per game (legal 1..3).
REQ-003 Parameter DELAY_FRAMES, default 60, frames waited after ball loss or level-up (legal 1..255).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 resetN  input  1  reset, asynchronous, active-low.
REQ-006 startOfFrame  input  1  one-clock pulse per video frame.
REQ-007 start_key  input  1  level signal from the start button, already debounced.
REQ-008 ball_lost  input  1  one-clock pulse: ball left through the bottom opening.
REQ-009 target_hit  input  1  one-clock pulse: ball hit a scoring target.
REQ-010 new_game  output  1  one-clock pulse: restart the ball and reopen the coil gate in the background drawer.
REQ-011 levelRGB  output  8  RGB332 wall colour for the background drawer.
REQ-012 level  output  2  current level, 0..3.
REQ-013 lives  output  2  remaining balls.
REQ-014 game_over  output  1  high while in S_OVER.

Function
REQ-015 States SHALL be S_IDLE, S_START, S_PLAY, S_LOST, S_LVLUP and S_OVER.
REQ-016 A start edge SHALL be start_key high in the current cycle and low in the previous registered cycle; a held key SHALL produce one edge only.
REQ-017 In S_IDLE or S_OVER, a start edge SHALL do four things on the same clock: set level=0, lives=LIVES, hits=0 and game_over=0; and move to S_START.
REQ-018 S_START SHALL last exactly one clock with new_game=1, then go to S_PLAY; new_game SHALL be 0 in every other state.
REQ-019 In S_PLAY, target_hit SHALL increment a 4-bit hit counter.
REQ-020 When the increment makes hits equal HITS_PER_LEVEL, the block SHALL clear hits, increment level (saturating at 3) and enter S_LVLUP.
REQ-021 In S_PLAY, ball_lost SHALL decrement lives (never below 0) and enter S_LOST.
REQ-022 If ball_lost and target_hit occur in the same cycle, ball_lost SHALL win and the hit SHALL be discarded.
REQ-023 In S_LOST and S_LVLUP, an 8-bit frame counter SHALL clear on entry and increment on each startOfFrame.
REQ-024 When the frame counter reaches DELAY_FRAMES, S_LVLUP SHALL go to S_START.
REQ-025 When the frame counter reaches DELAY_FRAMES, S_LOST SHALL go to S_OVER if lives==0, otherwise to S_START.
REQ-026 ball_lost, target_hit and start edges SHALL be ignored in any state not named for them above.
REQ-027 levelRGB SHALL be registered and SHALL change one clock after level or state changes, using this mapping: level0 8'h03, level1 8'h1C, level2 8'hE0, level3 8'hFC.
REQ-028 In S_OVER, levelRGB SHALL override the level mapping with 8'h92.
REQ-029 game_over SHALL be 1 exactly while the state is S_OVER.

Reset
REQ-030 While resetN is low, the state SHALL be S_IDLE.
REQ-031 While resetN is low, the outputs SHALL be level=0, lives=LIVES, new_game=0, game_over=0 and levelRGB=8'h03.
REQ-032 While resetN is low, hits, the frame counter and the previous-key register SHALL be 0.
REQ-033 Reset asserted in any state, including mid-delay, SHALL abort immediately with no new_game pulse.
REQ-034 A start_key already high when reset releases SHALL NOT count as an edge; start_key must go low and then high again.

Verification
REQ-035 Reset, start_key 0->1 -> new_game high for exactly 1 clock, 1 clock after the edge; state S_PLAY; lives=3; start_key held high -> no second pulse.
REQ-036 8 target_hit pulses in S_PLAY -> level=1; levelRGB=8'h1C one clock later; after 60 startOfFrame pulses -> one new_game pulse.
REQ-037 ball_lost and target_hit in the same cycle with hits=7 -> lives=2, hits stays 7, state S_LOST, level unchanged.
REQ-038 Three ball losses, each followed by 60 frames -> game_over=1, levelRGB=8'h92, ball_lost ignored; then a start edge -> level=0, lives=3, new_game pulses.
REQ-039 Level 3 plus 8 more hits -> level stays 3, levelRGB=8'hFC.
REQ-040 resetN low at frame 30 of an S_LOST delay -> immediate S_IDLE with all reset values, and no new_game pulse after release.
